// File: rtl/lfsr_gen_if.sv
// Control/status bundle for lfsr_gen: step/load controls in, state and period status out.
interface lfsr_gen_if #(
  parameter int WIDTH = 8
);
  logic             enable;
  logic             load;
  logic [WIDTH-1:0] seed_in;
  logic [WIDTH-1:0] data_out;
  logic             wrap;
  logic [WIDTH-1:0] period_len;
  logic             seed_err;

  modport master (
    output enable, load, seed_in,
    input  data_out, wrap, period_len, seed_err
  );

  modport slave (
    input  enable, load, seed_in,
    output data_out, wrap, period_len, seed_err
  );
endinterface

// File: rtl/lfsr_gen.sv
// Fibonacci/Galois LFSR with seed load, zero-seed guard and period measurement.
// Latency: one cycle from enable/load to data_out; no backpressure, steps whenever enabled.
module lfsr_gen #(
  parameter int             WIDTH = 8,
  parameter logic [WIDTH-1:0] TAPS = 8'hB8,
  parameter int             MODE  = 0,
  parameter logic [WIDTH-1:0] SEED = 1
) (
  input  logic       clk,
  input  logic       reset,
  lfsr_gen_if.slave  bus
);

  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] RST_SEED = (SEED == '0) ? ONE : SEED;

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] ref_seed;
  logic [WIDTH-1:0] step_cnt;
  logic [WIDTH-1:0] period_len;
  logic             wrap;
  logic             seed_err;
  logic [WIDTH-1:0] step_val;
  logic [WIDTH-1:0] load_val;
  logic             fb;

  always_comb begin
    fb       = ^(state & TAPS);
    step_val = {state[WIDTH-2:0], fb};
    if (MODE == 1) begin
      step_val = (state >> 1) ^ (state[0] ? TAPS : '0);
    end
    load_val = (bus.seed_in == '0) ? ONE : bus.seed_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= RST_SEED;
      ref_seed   <= RST_SEED;
      step_cnt   <= '0;
      period_len <= '0;
      wrap       <= 1'b0;
      seed_err   <= 1'b0;
    end else if (bus.load) begin
      state    <= load_val;
      ref_seed <= load_val;
      step_cnt <= '0;
      wrap     <= 1'b0;
      if (bus.seed_in == '0) begin
        seed_err <= 1'b1;
      end
    end else if (bus.enable) begin
      if (state == '0) begin
        // Upset into the lock-up state: restart the sequence from the reference seed.
        state    <= ref_seed;
        step_cnt <= '0;
        wrap     <= 1'b0;
        seed_err <= 1'b1;
      end else begin
        state <= step_val;
        if (step_val == ref_seed) begin
          wrap       <= 1'b1;
          period_len <= step_cnt + 1'b1;
          step_cnt   <= '0;
        end else begin
          wrap     <= 1'b0;
          step_cnt <= step_cnt + 1'b1;
        end
      end
    end else begin
      wrap <= 1'b0;
    end
  end

  assign bus.data_out   = state;
  assign bus.wrap       = wrap;
  assign bus.period_len = period_len;
  assign bus.seed_err   = seed_err;

endmodule

// File: tb/tb_lfsr_gen.sv
// Randomized bench for lfsr_gen: four configurations checked against an orbit-based reference model.
module tb_lfsr_gen;
  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;
  int   checks   = 0;
  int   failures = 0;

  // Instance configurations: W4 Fibonacci, W4 Galois, W8 Fibonacci, W8 Galois.
  int          cfg_w [NI] = '{4, 4, 8, 8};
  logic [31:0] cfg_t [NI] = '{32'hC, 32'hC, 32'hB8, 32'hB8};
  int          cfg_m [NI] = '{0, 1, 0, 1};

  logic        en   [NI];
  logic        ld   [NI];
  logic [31:0] sd   [NI];
  logic [31:0] dout [NI];
  logic [31:0] plen [NI];
  logic        wr   [NI];
  logic        er   [NI];

  lfsr_gen_if #(.WIDTH(4)) if0 ();
  lfsr_gen_if #(.WIDTH(4)) if1 ();
  lfsr_gen_if #(.WIDTH(8)) if2 ();
  lfsr_gen_if #(.WIDTH(8)) if3 ();

  lfsr_gen #(.WIDTH(4), .TAPS(4'hC),  .MODE(0), .SEED(4'h1)) u0 (.clk(clk), .reset(reset), .bus(if0));
  lfsr_gen #(.WIDTH(4), .TAPS(4'hC),  .MODE(1), .SEED(4'h1)) u1 (.clk(clk), .reset(reset), .bus(if1));
  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .MODE(0), .SEED(8'h0)) u2 (.clk(clk), .reset(reset), .bus(if2));
  lfsr_gen #(.WIDTH(8), .TAPS(8'hB8), .MODE(1), .SEED(8'h1)) u3 (.clk(clk), .reset(reset), .bus(if3));

  assign if0.enable = en[0]; assign if0.load = ld[0]; assign if0.seed_in = sd[0][3:0];
  assign if1.enable = en[1]; assign if1.load = ld[1]; assign if1.seed_in = sd[1][3:0];
  assign if2.enable = en[2]; assign if2.load = ld[2]; assign if2.seed_in = sd[2][7:0];
  assign if3.enable = en[3]; assign if3.load = ld[3]; assign if3.seed_in = sd[3][7:0];

  assign dout[0] = 32'(if0.data_out); assign plen[0] = 32'(if0.period_len);
  assign dout[1] = 32'(if1.data_out); assign plen[1] = 32'(if1.period_len);
  assign dout[2] = 32'(if2.data_out); assign plen[2] = 32'(if2.period_len);
  assign dout[3] = 32'(if3.data_out); assign plen[3] = 32'(if3.period_len);
  assign wr[0] = if0.wrap; assign er[0] = if0.seed_err;
  assign wr[1] = if1.wrap; assign er[1] = if1.seed_err;
  assign wr[2] = if2.wrap; assign er[2] = if2.seed_err;
  assign wr[3] = if3.wrap; assign er[3] = if3.seed_err;

  // Reference model: the state is the k-th element of the orbit of ref_seed.
  logic [31:0] m_ref  [NI];
  int          m_k    [NI];
  int          m_p    [NI];
  logic [31:0] m_plen [NI];
  logic        m_wrap [NI];
  logic        m_err  [NI];

  logic [3:0] fib_tab [16] = '{4'h1, 4'h2, 4'h4, 4'h9, 4'h3, 4'h6, 4'hD, 4'hA,
                               4'h5, 4'hB, 4'h7, 4'hF, 4'hE, 4'hC, 4'h8, 4'h1};
  logic [3:0] gal_tab [16] = '{4'h1, 4'hC, 4'h6, 4'h3, 4'hD, 4'hA, 4'h5, 4'hE,
                               4'h7, 4'hF, 4'hB, 4'h9, 4'h8, 4'h4, 4'h2, 4'h1};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mask_of(int i);
    return (32'h1 << cfg_w[i]) - 32'h1;
  endfunction

  function automatic logic [31:0] nxt(int i, logic [31:0] s);
    logic [31:0] r;
    if (cfg_m[i] == 0)
      r = ((s << 1) | 32'($countones(s & cfg_t[i]) % 2)) & mask_of(i);
    else
      r = (s >> 1) ^ (s[0] ? cfg_t[i] : 32'h0);
    return r;
  endfunction

  function automatic int orbit_len(int i, logic [31:0] s);
    logic [31:0] t = s;
    int          p = 0;
    do begin
      t = nxt(i, t);
      p++;
    end while (t != s && p < 70000);
    return p;
  endfunction

  function automatic logic [31:0] state_at(int i);
    logic [31:0] t = m_ref[i];
    for (int n = 0; n < m_k[i] % m_p[i]; n++) t = nxt(i, t);
    return t;
  endfunction

  task automatic model_edge();
    logic [31:0] v;
    for (int i = 0; i < NI; i++) begin
      if (reset) begin
        m_ref[i] = 32'h1; m_k[i] = 0; m_p[i] = orbit_len(i, 32'h1);
        m_plen[i] = 0; m_err[i] = 1'b0; m_wrap[i] = 1'b0;
      end else if (ld[i]) begin
        v = sd[i] & mask_of(i);
        if (v == 0) begin
          v = 32'h1;
          m_err[i] = 1'b1;
        end
        m_ref[i] = v; m_k[i] = 0; m_p[i] = orbit_len(i, v); m_wrap[i] = 1'b0;
      end else if (en[i]) begin
        m_k[i]++;
        m_wrap[i] = (m_k[i] % m_p[i] == 0);
        if (m_wrap[i]) m_plen[i] = 32'(m_p[i]);
      end else begin
        m_wrap[i] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("data%0d", i), dout[i], state_at(i));
      chk($sformatf("wrap%0d", i), 32'(wr[i]), 32'(m_wrap[i]));
      chk($sformatf("plen%0d", i), plen[i], m_plen[i]);
      chk($sformatf("err%0d", i),  32'(er[i]), 32'(m_err[i]));
    end
  endtask

  task automatic set_all(input logic e, input logic l, input logic [31:0] s);
    for (int i = 0; i < NI; i++) begin
      en[i] = e; ld[i] = l; sd[i] = s;
    end
  endtask

  initial begin
    bit seen2 [256];
    bit seen3 [256];
    int cnt;

    reset = 1'b1;
    set_all(1'b1, 1'b0, 32'h0);
    tick();
    tick();
    chk("rst_data", dout[0], 32'h1);
    chk("rst_data_seed0", dout[2], 32'h1);
    chk("rst_plen", plen[0], 32'h0);
    chk("rst_wrap", 32'(wr[0]), 32'h0);
    reset = 1'b0;

    // Free run: W4 tables for one period, W8 uniqueness over a full period.
    seen2[dout[2][7:0]] = 1'b1;
    seen3[dout[3][7:0]] = 1'b1;
    for (int s = 1; s <= 255; s++) begin
      tick();
      if (s <= 15) begin
        chk("fib_seq", dout[0], 32'(fib_tab[s]));
        chk("gal_seq", dout[1], 32'(gal_tab[s]));
      end
      if (s == 15) begin
        chk("fib_wrap15", 32'(wr[0]), 32'h1);
        chk("fib_plen15", plen[0], 32'd15);
        chk("gal_plen15", plen[1], 32'd15);
      end
      if (s < 255) begin
        chk("w8f_uniq", {30'h0, seen2[dout[2][7:0]], dout[2] == 0}, 32'h0);
        chk("w8g_uniq", {30'h0, seen3[dout[3][7:0]], dout[3] == 0}, 32'h0);
        seen2[dout[2][7:0]] = 1'b1;
        seen3[dout[3][7:0]] = 1'b1;
      end
    end
    chk("w8f_wrap255", 32'(wr[2]), 32'h1);
    chk("w8f_plen255", plen[2], 32'd255);
    chk("w8g_plen255", plen[3], 32'd255);

    // Reset mid-period after 7 steps.
    repeat (7) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_data", dout[0], 32'h1);
    chk("midrst_plen", plen[0], 32'h0);
    chk("midrst_wrap", 32'(wr[0]), 32'h0);
    repeat (15) tick();
    chk("midrst_wrap15", 32'(wr[0]), 32'h1);
    chk("midrst_plen15", plen[0], 32'd15);

    // Load 9 with enable in the same cycle, then 15 steps with enable gaps.
    set_all(1'b1, 1'b1, 32'h9);
    tick();
    set_all(1'b0, 1'b0, 32'h0);
    chk("load9_data", dout[0], 32'h9);
    cnt = 0;
    for (int c = 0; c < 400 && cnt < 15; c++) begin
      for (int i = 0; i < NI; i++) en[i] = ($urandom_range(0, 2) != 0);
      tick();
      if (en[0]) cnt++;
    end
    chk("gap_steps", 32'(cnt), 32'd15);
    chk("gap_wrap", 32'(wr[0]), 32'h1);
    chk("gap_data", dout[0], 32'h9);
    chk("gap_plen", plen[0], 32'd15);

    // Zero seed load.
    set_all(1'b1, 1'b1, 32'h0);
    tick();
    set_all(1'b0, 1'b0, 32'h0);
    chk("load0_data", dout[0], 32'h1);
    chk("load0_err", 32'(er[0]), 32'h1);

    // Random mix of steps, gaps and loads.
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++) begin
        en[i] = ($urandom_range(0, 9) < 7);
        ld[i] = ($urandom_range(0, 49) == 0);
        sd[i] = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      end
      tick();
    end
    chk("err_sticky", 32'(er[0]), 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/lfsr_gen.md
# lfsr_gen

Parametrised linear-feedback shift register. Supports configurable width, tap mask and Fibonacci/Galois topology, plus run-time seed loading, a step enable, zero-seed protection and automatic measurement of the sequence period. It serves as the pseudo-random source for test-pattern generation, scrambling and BIST stimulus in the design.

## Interface
- WIDTH, 8: register width in bits; legal range 2–32.
- TAPS, 8'hB8: feedback polynomial mask, WIDTH bits. The default is maximal-length for WIDTH=8.
- MODE, 0: topology select; 0 = Fibonacci, 1 = Galois.
- SEED, 1: state value after reset, WIDTH bits. SEED=0 is replaced by 1.

Ports:
- clk, input, 1: single clock; all state changes on the rising edge.
- reset, input, 1: synchronous, active-high reset.
- enable, input, 1: advance the register by one step this cycle.
- load, input, 1: load seed_in this cycle.
- seed_in, input, WIDTH: seed value, sampled when load=1.
- data_out, output, WIDTH: current LFSR state (registered).
- wrap, output, 1: one-cycle pulse when a step returns the state to the reference seed.
- period_len, output, WIDTH: length of the last completed period in steps (registered).
- seed_err, output, 1: sticky flag; a zero seed was loaded and substituted.

## Operation
Next-state function:
- Fibonacci: fb = XOR of data_out[i] for every i with TAPS[i]=1. next = {data_out[WIDTH-2:0], fb}.
- Galois: next = (data_out >> 1) ^ (data_out[0] ? TAPS : 0).

Reference seed:
- An internal register ref_seed holds the last loaded seed. After reset it holds SEED, or 1 if SEED=0.

Priority each cycle: reset > load > enable > hold.
- reset: data_out <= SEED (1 if SEED=0), ref_seed <= same, step_cnt <= 0, period_len <= 0, wrap <= 0, seed_err <= 0.
- load:
  - data_out <= seed_in and ref_seed <= seed_in.
  - If seed_in == 0, both instead take 1 and seed_err <= 1.
  - step_cnt <= 0 and wrap <= 0. period_len is retained.
  - enable in the same cycle is ignored.
- enable:
  - data_out <= next.
  - If next == ref_seed: wrap <= 1, period_len <= step_cnt + 1, step_cnt <= 0.
  - Otherwise: step_cnt <= step_cnt + 1 and wrap <= 0.
- hold: data_out, step_cnt, period_len and seed_err are unchanged; wrap <= 0.

Counter width rules:
- step_cnt is WIDTH bits, internal.
- The maximum period 2^WIDTH−1 fits in WIDTH bits, so no overflow occurs for valid seeds.
- With a non-maximal TAPS, the period reported is the length of the cycle actually containing ref_seed.

Zero-state guard:
- The all-zeros state is unreachable: zero seeds are substituted on reset and on load.
- If data_out is ever observed at 0 while enable=1 (e.g. an upset), the register reloads ref_seed instead of stepping, and seed_err <= 1.

Sticky flag:
- seed_err is cleared only by reset.

## Timing
- All outputs are registered. Latency from enable/load to data_out is one cycle.
- wrap is high for exactly the one cycle in which data_out == ref_seed after a step. It is never high after load or reset.
- period_len updates in the same cycle wrap rises.
- With enable held high continuously, wrap pulses every period_len cycles.
- enable gaps stretch the wall-clock time between pulses but do not change period_len.
- Reset mid-sequence restores the reset values on the next edge; any partial step_cnt is discarded.
- Load mid-sequence discards the partial count. The next period is measured from the new seed.

## Test plan
- Fibonacci, WIDTH=4, TAPS=4'hC, MODE=0, SEED=1, enable=1:
  - data_out = 1,2,4,9,3,6,D,A,5,B,7,F,E,C,8,1.
  - wrap pulses on the return to 1; period_len=15.
- Galois, WIDTH=4, TAPS=4'hC, MODE=1, SEED=1:
  - data_out = 1,C,6,3,D,A,5,E,7,F,B,9,8,4,2,1.
  - period_len=15.
- Default WIDTH=8, TAPS=8'hB8, both modes, free-running:
  - wrap pulses every 255 cycles; period_len=255.
  - No state repeats within a period and 0 never appears.
- Load seed_in=0 at an arbitrary point:
  - data_out=1 next cycle; seed_err=1 and stays set until reset.
  - The next period is measured from 1.
- Load 4'h9 with enable=1 in the same cycle (WIDTH=4 Fibonacci):
  - data_out=9, not the stepped value.
  - After 15 enabled steps with random enable gaps, wrap pulses at 9; period_len=15.
- Reset asserted mid-period (after 7 steps, with period_len previously 15):
  - Next cycle data_out=SEED, period_len=0, wrap=0, seed_err=0.
  - Full 15-step period measured again afterwards.
